// File: rtl/uart_frame_wrapper.sv
// Frames UART receive bytes into cmd + DATA_BYTES data bytes with an inter-byte timeout,
// and serialises a RESP_BYTES-wide response MSB byte first. Optional macro: CHECKSUM_EN.
module uart_frame_wrapper #(
    parameter int unsigned DATA_BYTES  = 2,
    parameter int unsigned RESP_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_rdy,
    output logic                    clr_rx_rdy,
    output logic [7:0]              tx_data,
    output logic                    trmt,
    input  logic                    tx_done,
    output logic [7:0]              cmd,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    output logic                    frame_err,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    send_resp,
    output logic                    resp_busy,
    output logic                    resp_sent
);

    localparam int unsigned DW    = 8 * DATA_BYTES;
    localparam int unsigned RW    = 8 * RESP_BYTES;
    localparam int unsigned IDX_W = $clog2(DATA_BYTES + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CNT_W = $clog2(RESP_BYTES + 1);

`ifdef CHECKSUM_EN
    typedef enum logic [1:0] {
        RX_WAIT_CMD = 2'd0,
        RX_GET_DATA = 2'd1,
        RX_GET_CHK  = 2'd2
    } rx_state_t;
`else
    typedef enum logic [0:0] {
        RX_WAIT_CMD = 1'b0,
        RX_GET_DATA = 1'b1
    } rx_state_t;
`endif

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_next;
    logic [IDX_W-1:0] idx;
    logic [TMR_W-1:0] tmr;
    logic             in_frame;
    logic             timeout;
    logic             store_cmd;
    logic             store_data;
    logic             set_rdy;
    logic             drop;
`ifdef CHECKSUM_EN
    logic [7:0]       chk_sum;
`endif

    tx_state_t        tx_state;
    tx_state_t        tx_next;
    logic [RW-1:0]    shreg;
    logic [RW-1:0]    sh_next;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             advance;

    // Every presented byte is consumed in the cycle it appears.
    assign clr_rx_rdy = rx_rdy;

    assign in_frame = (rx_state != RX_WAIT_CMD);
    assign timeout  = in_frame && !rx_rdy && (tmr == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_WAIT_CMD;
        end else begin
            rx_state <= rx_next;
        end
    end

    // Receive next-state and datapath strobes.
    always_comb begin
        rx_next    = rx_state;
        store_cmd  = 1'b0;
        store_data = 1'b0;
        set_rdy    = 1'b0;
        drop       = 1'b0;
        case (rx_state)
            RX_WAIT_CMD: begin
                if (rx_rdy) begin
                    store_cmd = 1'b1;
                    rx_next   = RX_GET_DATA;
                end
            end
            RX_GET_DATA: begin
                if (rx_rdy) begin
                    store_data = 1'b1;
                    if (idx == IDX_W'(DATA_BYTES - 1)) begin
`ifdef CHECKSUM_EN
                        rx_next = RX_GET_CHK;
`else
                        set_rdy = 1'b1;
                        rx_next = RX_WAIT_CMD;
`endif
                    end
                end else if (timeout) begin
                    drop    = 1'b1;
                    rx_next = RX_WAIT_CMD;
                end
            end
`ifdef CHECKSUM_EN
            RX_GET_CHK: begin
                if (rx_rdy) begin
                    if (rx_data == ~chk_sum) begin
                        set_rdy = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                    rx_next = RX_WAIT_CMD;
                end else if (timeout) begin
                    drop    = 1'b1;
                    rx_next = RX_WAIT_CMD;
                end
            end
`endif
            default: begin
                rx_next = RX_WAIT_CMD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= 8'd0;
            data      <= '0;
            idx       <= '0;
            tmr       <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (store_cmd) begin
                cmd <= rx_data;
                idx <= '0;
            end
            if (store_data) begin
                idx <= idx + IDX_W'(1);
            end
            // Slot 0 occupies the top byte of data.
            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                if (store_data && (idx == IDX_W'(i))) begin
                    data[DW-1-8*i -: 8] <= rx_data;
                end
            end
            if (!in_frame || rx_rdy || timeout) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end
            if (set_rdy) begin
                cmd_rdy <= 1'b1;
            end else if (store_cmd || clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            frame_err <= drop;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_sum <= 8'd0;
        end else if (store_cmd) begin
            chk_sum <= rx_data;
        end else if (store_data) begin
            chk_sum <= chk_sum + rx_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // Transmit next-state and shift strobes.
    always_comb begin
        tx_next = tx_state;
        load    = 1'b0;
        advance = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (send_resp) begin
                    load    = 1'b1;
                    tx_next = TX_START;
                end
            end
            TX_START: begin
                tx_next = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (tx_done) begin
                    advance = 1'b1;
                    tx_next = (cnt == CNT_W'(1)) ? TX_IDLE : TX_START;
                end
            end
            default: begin
                tx_next = TX_IDLE;
            end
        endcase
    end

    assign sh_next = shreg << 8;

    // trmt and tx_data are set on the edge entering START so they are valid during it.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            tx_data   <= 8'd0;
            trmt      <= 1'b0;
            resp_busy <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            trmt      <= load || (advance && (cnt != CNT_W'(1)));
            resp_sent <= advance && (cnt == CNT_W'(1));
            resp_busy <= (tx_next != TX_IDLE);
            if (load) begin
                shreg   <= resp;
                cnt     <= CNT_W'(RESP_BYTES);
                tx_data <= resp[RW-1 -: 8];
            end else if (advance) begin
                shreg <= sh_next;
                cnt   <= cnt - CNT_W'(1);
                if (cnt != CNT_W'(1)) begin
                    tx_data <= sh_next[RW-1 -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_wrapper.sv
// Randomised bench for uart_frame_wrapper against a queue-based frame/response model,
// plus directed literal checks; follows CHECKSUM_EN when defined.
module tb_uart_frame_wrapper;

    localparam int unsigned DB = 2;
    localparam int unsigned RB = 2;
    localparam int unsigned TO = 10;
`ifdef CHECKSUM_EN
    localparam int unsigned FL = DB + 2;
`else
    localparam int unsigned FL = DB + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rdy;
    logic          clr_rx_rdy;
    logic [7:0]    tx_data;
    logic          trmt;
    logic          tx_done;
    logic [7:0]    cmd;
    logic [8*DB-1:0] data;
    logic          cmd_rdy;
    logic          clr_cmd_rdy;
    logic          frame_err;
    logic [8*RB-1:0] resp;
    logic          send_resp;
    logic          resp_busy;
    logic          resp_sent;

    uart_frame_wrapper #(.DATA_BYTES(DB), .RESP_BYTES(RB), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done), .cmd(cmd), .data(data),
        .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .frame_err(frame_err), .resp(resp),
        .send_resp(send_resp), .resp_busy(resp_busy), .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int fixed_dly = 0;
    bit spurious_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: the partial frame as a byte list, the response as a byte list.
    logic [7:0]      m_cmd;
    logic [8*DB-1:0] m_data;
    logic [7:0]      m_tx_data;
    bit              m_cmd_rdy, m_frame_err, m_trmt, m_resp_sent;
    logic [7:0]      fq[$];
    logic [7:0]      txq[$];
    int              m_idle;
    int              tx_phase;

    initial begin
        int  n;
        bit  done;
        logic [7:0] sum;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cmd = 8'd0; m_data = '0; m_tx_data = 8'd0;
                m_cmd_rdy = 0; m_frame_err = 0; m_trmt = 0; m_resp_sent = 0;
                fq.delete(); txq.delete(); m_idle = 0; tx_phase = 0;
            end else begin
                m_frame_err = 0;
                done = 0;
                if (rx_rdy) begin
                    m_idle = 0;
                    if (fq.size() == 0) begin
                        m_cmd = rx_data;
                        m_cmd_rdy = 0;
                        fq.push_back(rx_data);
                    end else begin
                        fq.push_back(rx_data);
                        n = fq.size();
                        if (n <= int'(DB) + 1) m_data[8*DB-1-8*(n-2) -: 8] = rx_data;
                        if (n == int'(FL)) begin
                            done = 1;
`ifdef CHECKSUM_EN
                            sum = 8'd0;
                            for (int i = 0; i < n - 1; i++) sum = sum + fq[i];
                            done = ((~sum) == fq[n-1]);
`endif
                            if (done) m_cmd_rdy = 1;
                            else m_frame_err = 1;
                            fq.delete();
                        end
                    end
                end else if (fq.size() != 0) begin
                    if (m_idle == int'(TO) - 1) begin
                        m_frame_err = 1;
                        fq.delete();
                        m_idle = 0;
                    end else begin
                        m_idle++;
                    end
                end
                if (!done && clr_cmd_rdy) m_cmd_rdy = 0;

                m_trmt = 0;
                m_resp_sent = 0;
                case (tx_phase)
                    0: if (send_resp) begin
                        txq.delete();
                        for (int i = int'(RB) - 1; i >= 0; i--) txq.push_back(resp[8*i +: 8]);
                        m_tx_data = txq[0];
                        m_trmt = 1;
                        tx_phase = 1;
                    end
                    1: tx_phase = 2;
                    default: if (tx_done) begin
                        void'(txq.pop_front());
                        if (txq.size() == 0) begin
                            m_resp_sent = 1;
                            tx_phase = 0;
                        end else begin
                            m_tx_data = txq[0];
                            m_trmt = 1;
                            tx_phase = 1;
                        end
                    end
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("clr_rx_rdy", clr_rx_rdy, rx_rdy);
            chk("cmd", cmd, m_cmd);
            chk("data", data, m_data);
            chk("cmd_rdy", cmd_rdy, m_cmd_rdy);
            chk("frame_err", frame_err, m_frame_err);
            chk("trmt", trmt, m_trmt);
            chk("tx_data", tx_data, m_tx_data);
            chk("resp_busy", resp_busy, tx_phase != 0);
            chk("resp_sent", resp_sent, m_resp_sent);
        end
    end

    // Transmitter stand-in: tx_done some cycles after each trmt.
    initial begin
        int pend = 0;
        tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) tx_done = 1'b1;
            end else if (spurious_en && $urandom_range(0, 19) == 0) begin
                tx_done = 1'b1;
            end
            if (trmt) pend = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 6));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_rdy = 1'b1;
        rx_data = b;
        tick();
        rx_rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1);
        send_byte(c);
        send_byte(d0);
        send_byte(d1);
`ifdef CHECKSUM_EN
        send_byte(~(c + d0 + d1));
`endif
    endtask

    task automatic wait_trmt(input string nm);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (trmt) found = 1;
        end
        chk(nm, found, 1);
    endtask

    task automatic wait_sent(input string nm);
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (resp_sent) found = 1;
        end
        chk(nm, found, 1);
    endtask

    initial begin
        int gap = 0;
        int r;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'd0; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = '0;
        tick();
        tick();
        chk_on = 1'b1;
        chk("rst_cmd", cmd, 8'h00);
        chk("rst_cmd_rdy", cmd_rdy, 0);
        chk("rst_trmt", trmt, 0);
        chk("rst_busy", resp_busy, 0);
        rst = 1'b0;

        // Basic frame: completion flagged on the final byte's edge.
        send_byte(8'hA5);
        send_byte(8'h12);
        chk("f1_rdy_early", cmd_rdy, 0);
        send_byte(8'h34);
`ifdef CHECKSUM_EN
        send_byte(8'h14);
`endif
        chk("f1_rdy", cmd_rdy, 1);
        chk("f1_cmd", cmd, 8'hA5);
        chk("f1_data", data, 16'h1234);

        // New cmd byte drops cmd_rdy; set beats clear on completion.
        send_byte(8'h07);
        chk("f2_rdy_clr", cmd_rdy, 0);
        chk("f2_cmd", cmd, 8'h07);
        send_byte(8'h08);
`ifdef CHECKSUM_EN
        send_byte(8'h09);
        rx_data = 8'hE7;
`else
        rx_data = 8'h09;
`endif
        rx_rdy = 1'b1;
        clr_cmd_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        chk("f2_set_wins", cmd_rdy, 1);
        chk("f2_data", data, 16'h0809);
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        chk("f2_ack", cmd_rdy, 0);

        // Timeout after TO idle cycles in a partial frame.
        send_byte(8'h55);
        send_byte(8'h01);
        repeat (TO - 1) tick();
        chk("to_not_yet", frame_err, 0);
        tick();
        chk("to_err", frame_err, 1);
        chk("to_rdy", cmd_rdy, 0);
        tick();
        chk("to_pulse_end", frame_err, 0);
        send_frame(8'h66, 8'hAB, 8'hCD);
        chk("to_next_cmd", cmd, 8'h66);
        chk("to_next_data", data, 16'hABCD);
        chk("to_next_rdy", cmd_rdy, 1);

        // A byte on the last allowed idle cycle is accepted.
        send_byte(8'h11);
        repeat (TO - 1) tick();
        send_byte(8'h22);
        chk("edge_no_err1", frame_err, 0);
        repeat (TO - 1) tick();
        send_byte(8'h33);
`ifdef CHECKSUM_EN
        send_byte(8'h99);
`endif
        chk("edge_rdy", cmd_rdy, 1);
        chk("edge_data", data, 16'h2233);

        // Two-byte response, ignored send while busy, back-to-back send.
        fixed_dly = 20;
        resp = 16'hBEEF;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("tx1_trmt", trmt, 1);
        chk("tx1_byte", tx_data, 8'hBE);
        tick();
        chk("tx1_trmt_pulse", trmt, 0);
        resp = 16'h1234;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        wait_trmt("tx1_second_trmt");
        chk("tx1_byte2", tx_data, 8'hEF);
        wait_sent("tx1_sent");
        resp = 16'h5A3C;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        chk("tx2_b2b_trmt", trmt, 1);
        chk("tx2_b2b_byte", tx_data, 8'h5A);
        wait_trmt("tx2_second_trmt");
        chk("tx2_byte2", tx_data, 8'h3C);
        wait_sent("tx2_sent");
        tick();
        chk("tx2_idle", resp_busy, 0);

        // Reset mid-frame and mid-response.
        send_byte(8'h77);
        resp = 16'hCAFE;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_cmd", cmd, 8'h00);
        chk("rst2_data", data, 16'h0000);
        chk("rst2_busy", resp_busy, 0);
        chk("rst2_tx_data", tx_data, 8'h00);
        repeat (25) tick();
        send_frame(8'h3C, 8'hDE, 8'hAD);
        chk("rst2_frame_cmd", cmd, 8'h3C);
        chk("rst2_frame_data", data, 16'hDEAD);
        chk("rst2_frame_rdy", cmd_rdy, 1);

`ifdef CHECKSUM_EN
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h9F);
        chk("cs_good", cmd_rdy, 1);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h00);
        chk("cs_bad_err", frame_err, 1);
        chk("cs_bad_rdy", cmd_rdy, 0);
`endif

        // Randomised traffic on both paths.
        fixed_dly = 0;
        spurious_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (gap == 0) begin
                rx_rdy = 1'b1;
                rx_data = 8'($urandom);
                r = int'($urandom_range(0, 9));
                if (r < 6) gap = int'($urandom_range(0, 2));
                else if (r < 8) gap = int'($urandom_range(3, 8));
                else gap = int'($urandom_range(TO - 2, TO + 1));
            end else begin
                rx_rdy = 1'b0;
                gap--;
            end
            clr_cmd_rdy = ($urandom_range(0, 7) == 0);
            send_resp = ($urandom_range(0, 3) == 0);
            resp = (8*RB)'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        repeat (30) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
